switch_debounce: RTL and testbench

//  Conditions the 24 raw board DIP switches before the CPU switch-input latch samples them.

---
 rtl/switch_pkg.sv | 14 +
 rtl/debounce_bit.sv | 45 ++++
 rtl/switch_debounce.sv | 87 ++++++++
 tb/tb_switch_debounce.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/switch_pkg.sv
// Shared constants for the DIP switch debouncer.
// Holds the switch bus width, default timing parameters and a counter-width helper.
package switch_pkg;

   localparam int unsigned SW_WIDTH               = 24;
   localparam int unsigned DEFAULT_TICK_DIV       = 23000;
   localparam int unsigned DEFAULT_STABLE_SAMPLES = 4;

   // Counter width able to hold 0..n-1; never narrower than one bit.
   function automatic int unsigned cnt_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// Single-bit stability debouncer: accepts a new level after STABLE_SAMPLES
// consecutive sample ticks that all disagree with the current clean level.
module debounce_bit
   import switch_pkg::*;
#(
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic clock,
   input  logic reset,
   input  logic sync_bit,
   input  logic tick,
   output logic clean,
   output logic upd
);

   localparam int unsigned    CW   = cnt_width(STABLE_SAMPLES + 1);
   localparam logic [CW-1:0] LAST = CW'(STABLE_SAMPLES - 1);

   logic [CW-1:0] cnt;
   logic          differ;

   assign differ = sync_bit ^ clean;

   always_comb begin
      upd = tick & differ & (cnt == LAST);
   end

   // Any agreeing sample restarts the window, so a bounce costs a full window.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         cnt   <= '0;
         clean <= 1'b0;
      end else if (tick) begin
         if (!differ) begin
            cnt <= '0;
         end else if (cnt == LAST) begin
            clean <= sync_bit;
            cnt   <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/switch_debounce.sv
// DIP switch conditioner: 2-flop synchroniser, shared sample tick, per-bit debouncers.
// Optional sticky change flags enabled by defining SWITCH_DEBOUNCE_EDGE_LATCH_EN.
module switch_debounce
   import switch_pkg::*;
#(
   parameter int unsigned TICK_DIV       = DEFAULT_TICK_DIV,
   parameter int unsigned STABLE_SAMPLES = DEFAULT_STABLE_SAMPLES
) (
   input  logic                clock,
   input  logic                reset,
   input  logic [SW_WIDTH-1:0] sw_raw,
   output logic [SW_WIDTH-1:0] sw_clean,
   output logic                sw_changed,
   input  logic                clr_flags,
   output logic [SW_WIDTH-1:0] change_flags
);

   localparam int unsigned    TW        = cnt_width(TICK_DIV);
   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);

   logic [SW_WIDTH-1:0] sync1;
   logic [SW_WIDTH-1:0] sync2;
   logic [SW_WIDTH-1:0] upd;
   logic [TW-1:0]       tick_cnt;
   logic                tick;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sync1 <= '0;
         sync2 <= '0;
      end else begin
         sync1 <= sw_raw;
         sync2 <= sync1;
      end
   end

   assign tick = (tick_cnt == TICK_LAST);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         tick_cnt <= '0;
      end else if (tick) begin
         tick_cnt <= '0;
      end else begin
         tick_cnt <= tick_cnt + 1'b1;
      end
   end

   for (genvar g = 0; g < SW_WIDTH; g++) begin : g_bit
      debounce_bit #(
         .STABLE_SAMPLES (STABLE_SAMPLES)
      ) u_debounce_bit (
         .clock    (clock),
         .reset    (reset),
         .sync_bit (sync2[g]),
         .tick     (tick),
         .clean    (sw_clean[g]),
         .upd      (upd[g])
      );
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         sw_changed <= 1'b0;
      end else begin
         sw_changed <= |upd;
      end
   end

`ifdef SWITCH_DEBOUNCE_EDGE_LATCH_EN
   // A clear in the same cycle as an update keeps the updating bits set.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         change_flags <= '0;
      end else if (clr_flags) begin
         change_flags <= upd;
      end else begin
         change_flags <= change_flags | upd;
      end
   end
`else
   logic unused_clr_flags;
   assign unused_clr_flags = clr_flags;
   assign change_flags     = '0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Self-checking bench for switch_debounce (TICK_DIV=4, STABLE_SAMPLES=3).
// A run-length model of the debounce rules is compared with the DUT every cycle.
module tb_switch_debounce;

   localparam int unsigned TD = 4;
   localparam int unsigned SS = 3;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [23:0] sw_raw = '0;
   logic        clr_flags = 1'b0;
   logic [23:0] sw_clean;
   logic        sw_changed;
   logic [23:0] change_flags;

   switch_debounce #(
      .TICK_DIV       (TD),
      .STABLE_SAMPLES (SS)
   ) dut (
      .clock        (clock),
      .reset        (reset),
      .sw_raw       (sw_raw),
      .sw_clean     (sw_clean),
      .sw_changed   (sw_changed),
      .clr_flags    (clr_flags),
      .change_flags (change_flags)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Model state: raw history, cycles since reset, per-bit disagreeing run length.
   logic [23:0] m_s1, m_s2, m_clean, m_flags;
   logic        m_changed;
   int          m_n;
   int          m_run [24];

   int          n_pulse;
   int          n_change;
   logic [23:0] prev_clean;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_s1 = '0; m_s2 = '0; m_clean = '0; m_flags = '0;
      m_changed = 1'b0; m_n = 0;
      for (int i = 0; i < 24; i++) m_run[i] = 0;
   endtask

   task automatic model_update();
      logic [23:0] u;
      u = '0;
      if ((m_n % TD) == TD - 1) begin
         for (int i = 0; i < 24; i++) begin
            if (m_s2[i] != m_clean[i]) begin
               m_run[i] = m_run[i] + 1;
               if (m_run[i] == SS) begin
                  m_clean[i] = m_s2[i];
                  m_run[i]   = 0;
                  u[i]       = 1'b1;
               end
            end else begin
               m_run[i] = 0;
            end
         end
      end
      m_changed = |u;
`ifdef SWITCH_DEBOUNCE_EDGE_LATCH_EN
      m_flags = clr_flags ? u : (m_flags | u);
`else
      m_flags = '0;
`endif
      m_s2 = m_s1;
      m_s1 = sw_raw;
      m_n  = m_n + 1;
   endtask

   // One clock: advance model at the edge, compare at the falling edge.
   task automatic step();
      @(posedge clock);
      if (reset) model_reset();
      else model_update();
      @(negedge clock);
      check("cycle", {15'd0, change_flags, sw_changed, sw_clean},
                     {15'd0, m_flags, m_changed, m_clean});
      if (sw_changed) n_pulse++;
      if (sw_clean != prev_clean) n_change++;
      prev_clean = sw_clean;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic do_reset(input logic [23:0] raw);
      sw_raw = raw;
      reset  = 1'b1;
      model_reset();
      run(2);
      reset = 1'b0;
      prev_clean = sw_clean;
   endtask

   // Cycles after release until bit b of sw_clean is set; 0 when the bound expires.
   task automatic wait_bit(input int b, input int limit, output int k);
      k = 0;
      for (int i = 1; i <= limit; i++) begin
         step();
         if (sw_clean[b]) begin
            k = i;
            break;
         end
      end
   endtask

   int k;

   initial begin
      model_reset();
      prev_clean = '0;
      n_pulse = 0; n_change = 0;

      // 1: reset with all pins high
      sw_raw = 24'hFFFFFF;
      reset  = 1'b1;
      run(3);
      check("reset_clean", {40'd0, sw_clean}, 64'd0);
      check("reset_changed", {63'd0, sw_changed}, 64'd0);
      check("reset_flags", {40'd0, change_flags}, 64'd0);

      // 2: bit 0 held high through release
      do_reset(24'h000001);
      n_pulse = 0;
      wait_bit(0, 20, k);
      check("bit0_latency", 64'(k), 64'd12);
      run(12);
      check("bit0_pulses", 64'(n_pulse), 64'd1);
      check("bit0_clean", {40'd0, sw_clean}, 64'h1);

      // 3: bit 5 bouncing every 3 cycles never settles
      n_pulse = 0;
      for (int i = 0; i < 20; i++) begin
         sw_raw[5] = ~sw_raw[5];
         run(3);
      end
      sw_raw[5] = 1'b0;
      run(16);
      check("bounce_clean5", {63'd0, sw_clean[5]}, 64'd0);
      check("bounce_pulses", 64'(n_pulse), 64'd0);

      // 4: step 0 -> A5A5A5
      sw_raw = '0;
      run(20);
      check("zero_clean", {40'd0, sw_clean}, 64'd0);
      n_pulse = 0; n_change = 0;
      sw_raw = 24'hA5A5A5;
      run(20);
      check("step_clean", {40'd0, sw_clean}, 64'hA5A5A5);
      check("step_pulses", 64'(n_pulse), 64'd1);
      check("step_changes", 64'(n_change), 64'd1);

      // 5: reset mid-window discards progress
      do_reset(24'h0);
      sw_raw[3] = 1'b1;
      run(9);
      do_reset(24'h000008);
      check("midreset_clean", {40'd0, sw_clean}, 64'd0);
      wait_bit(3, 20, k);
      check("midreset_latency", 64'(k), 64'd12);

`ifdef SWITCH_DEBOUNCE_EDGE_LATCH_EN
      // 6: sticky flags, clear, and set-beats-clear
      do_reset(24'h0);
      sw_raw[7] = 1'b1;
      run(16);
      check("flag7_set", {40'd0, change_flags}, 64'h80);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("flag7_clr", {40'd0, change_flags}, 64'h0);
      do_reset(24'h000004);
      run(11);
      clr_flags = 1'b1;
      step();
      clr_flags = 1'b0;
      check("flag2_setwins", {40'd0, change_flags}, 64'h4);
`else
      // Flags stay zero and clr_flags has no effect
      do_reset(24'h0);
      sw_raw[7] = 1'b1;
      clr_flags = 1'b1;
      run(16);
      clr_flags = 1'b0;
      check("flags_off_clean", {40'd0, sw_clean}, 64'h80);
      check("flags_off", {40'd0, change_flags}, 64'h0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
